mtm_alu_serializer: RTL and testbench
=====================================

// Module: mtm_alu_serializer
// PURPOSE
//  Transmit side of the MTM ALU serial link. Captures a result word and control
//  byte from the ALU core and shifts it out on sout as 11-bit frames: start 0,
//  type bit (0=DATA, 1=CTL), 8 payload bits MSB first, stop 1. The line idles high.
//  Sits between the core's registered C/CTL_out outputs and the chip pad sout.
// PARAMETERS
//  CLKS_PER_BIT  1  clk cycles each serial bit is held on sout (>=1)
// PORTS
//  clk      in   1   clock, all logic on posedge
//  rst_n    in   1   reset, synchronous, active-low
//  C_in     in   32  result word from core (C)
//  CTL_in   in   8   control byte from core (CTL_out); 8'hFF = no result
//  sout     out  1   serial output line, idle high
//  busy     out  1   high while a packet is being shifted out
// BEHAVIOUR
//  Reset: sout=1, busy=0, state=IDLE, all counters and shift registers cleared.
//   A reset asserted mid-packet aborts it; sout=1 on the next edge with no partial frame.
//  Capture: in IDLE, on any cycle with CTL_in!=8'hFF, register C_in/CTL_in, choose pkt type:
//   CTL_in[7]==0 -> OK packet: 4 DATA frames C[31:24],C[23:16],C[15:8],C[7:0],
//                   then 1 CTL frame carrying CTL_in (55 bit-times).
//   CTL_in[7]==1 -> ERROR packet: 1 CTL frame carrying CTL_in only (11 bit-times).
//  Inputs are ignored while busy=1. No queuing; a result presented then is dropped.
//  FSM: IDLE -> START -> TYPE -> DATA(8 bits) -> STOP -> (START if bytes remain, else IDLE).
//   Each state/bit lasts exactly CLKS_PER_BIT cycles (bit counter 0..CLKS_PER_BIT-1).
//   Byte counter 0..4 selects the payload; the type bit is 1 only for the final byte.
//  Timing: capture at edge N -> sout=0 (start) and busy=1 from edge N+1.
//   Frames are back-to-back with no idle between bytes of one packet.
//   busy falls and state=IDLE on the edge ending the last stop bit. A new capture is
//   legal in that IDLE cycle, so packets are separated by >=1 idle-high clk.
//  sout is driven from a register (no combinational path from inputs to sout).
//  CTL payload is sent verbatim; this block never computes CRC or flags.
// TESTING
//  1 OK pkt: C_in=32'h12345678, CTL_in=8'h0A one cycle, CLKS_PER_BIT=1 -> sout
//    frames 0_0_00010010_1, 0_0_00110100_1, 0_0_01010110_1, 0_0_01111000_1,
//    0_1_00001010_1; busy high exactly 55 clks; sout=1 afterwards.
//  2 ERROR pkt: CTL_in=8'hC9, C_in=X -> single frame 0_1_11001001_1, busy 11 clks.
//  3 Idle: CTL_in=8'hFF held 100 clks -> sout stays 1, busy stays 0.
//  4 Overlap: CTL_in=8'h0A at edge N, CTL_in=8'hA5 at N+5 -> only the OK packet is sent;
//    8'hA5 is dropped. Then 8'hA5 in the first idle cycle -> ERROR frame starts next clk.
//  5 Reset mid-packet: rst_n=0 during byte 2 data bits -> sout=1, busy=0 next edge;
//    a new 8'h93 after release produces one clean ERROR frame.
//  6 CLKS_PER_BIT=4: repeat test 1 -> every bit held 4 clks, busy high 220 clks.

Source files
------------

// File: rtl/mtm_alu_serializer.sv
// Transmit side of the MTM ALU serial link: captures a core result and shifts it
// out on sout as 11-bit frames (start, type, 8 payload bits MSB first, stop).
`timescale 1ns/1ps
module mtm_alu_serializer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] C_in,
  input  logic [7:0]  CTL_in,
  output logic        sout,
  output logic        busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, TYPE, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [2:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]   c_q, c_d;
  logic [7:0]    ctl_q, ctl_d;
  logic          sout_q, sout_d;
  logic          busy_q, busy_d;

  logic [7:0]    cur_byte;
  logic          last_byte;
  logic          bit_end;

  // Byte 0..3 walk the result word high to low; byte 4 is the control byte.
  function automatic logic [7:0] payload(input logic [2:0] idx, input logic [31:0] c,
                                         input logic [7:0] ctl);
    case (idx)
      3'd0:    payload = c[31:24];
      3'd1:    payload = c[23:16];
      3'd2:    payload = c[15:8];
      3'd3:    payload = c[7:0];
      default: payload = ctl;
    endcase
  endfunction

  assign cur_byte  = payload(byte_cnt_q, c_q, ctl_q);
  assign last_byte = (byte_cnt_q == 3'd4);
  assign bit_end   = (clk_cnt_q == CLK_LAST);

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    c_d        = c_q;
    ctl_d      = ctl_q;
    sout_d     = sout_q;
    busy_d     = busy_q;

    if (state_q != IDLE) begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + CW'(1);
    end

    // sout_d is the value of the bit that begins on this edge, so sout stays registered.
    case (state_q)
      IDLE: begin
        if (CTL_in != 8'hFF) begin
          c_d        = C_in;
          ctl_d      = CTL_in;
          byte_cnt_d = CTL_in[7] ? 3'd4 : 3'd0;
          clk_cnt_d  = '0;
          state_d    = START;
          sout_d     = 1'b0;
          busy_d     = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = TYPE;
          sout_d  = last_byte;
        end
      end
      TYPE: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
          sout_d    = cur_byte[7];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
            sout_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            sout_d    = cur_byte[3'd6 - bit_cnt_q];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (last_byte) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            sout_d  = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
            state_d    = START;
            sout_d     = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        sout_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      c_q        <= '0;
      ctl_q      <= '0;
      sout_q     <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      c_q        <= c_d;
      ctl_q      <= ctl_d;
      sout_q     <= sout_d;
      busy_q     <= busy_d;
    end
  end

  assign sout = sout_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Bench for mtm_alu_serializer: vector table, directed corner sequences and random
// traffic against a bit-queue model of the expected sout line (CLKS_PER_BIT 1 and 4).
`timescale 1ns/1ps
module tb_mtm_alu_serializer;

  localparam int CPB4 = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] c1, c4;
  logic [7:0]  ctl1, ctl4;
  logic        sout1, busy1, sout4, busy4;

  always #5 clk = ~clk;

  mtm_alu_serializer #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .C_in(c1), .CTL_in(ctl1), .sout(sout1), .busy(busy1));

  mtm_alu_serializer #(.CLKS_PER_BIT(CPB4)) dut4 (
    .clk(clk), .rst_n(rst_n), .C_in(c4), .CTL_in(ctl4), .sout(sout4), .busy(busy4));

  int n_pass = 0;
  int n_total = 0;
  bit mdl_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Whole packet as a bit string, first transmitted bit at position len-1.
  function automatic int pkt_len(input logic [7:0] ctl);
    return ctl[7] ? 11 : 55;
  endfunction

  function automatic logic [54:0] pkt_bits(input logic [31:0] c, input logic [7:0] ctl);
    logic [54:0] s;
    int nb;
    s  = '0;
    nb = ctl[7] ? 1 : 5;
    for (int b = 0; b < nb; b++) begin
      logic [7:0] pl;
      pl = (b == nb - 1) ? ctl : c[31 - 8*b -: 8];
      s  = {s[43:0], 1'b0, (b == nb - 1), pl, 1'b1};
    end
    return s;
  endfunction

  function automatic logic pkt_bit(input logic [31:0] c, input logic [7:0] ctl, input int i);
    logic [54:0] s;
    s = pkt_bits(c, ctl);
    return s[i];
  endfunction

  // Model: queue holds the sout value of every upcoming clock; empty means idle.
  logic q1[$];
  logic q4[$];

  always @(posedge clk) begin
    if (!rst_n) q1.delete();
    else if (q1.size() != 0) void'(q1.pop_front());
    else if (ctl1 != 8'hFF)
      for (int i = pkt_len(ctl1) - 1; i >= 0; i--) q1.push_back(pkt_bit(c1, ctl1, i));
  end

  always @(posedge clk) begin
    if (!rst_n) q4.delete();
    else if (q4.size() != 0) void'(q4.pop_front());
    else if (ctl4 != 8'hFF)
      for (int i = pkt_len(ctl4) - 1; i >= 0; i--)
        for (int k = 0; k < CPB4; k++) q4.push_back(pkt_bit(c4, ctl4, i));
  end

  always @(negedge clk) begin
    if (mdl_on) begin
      check("mdl1_sout", 64'(sout1), 64'((q1.size() != 0) ? q1[0] : 1'b1));
      check("mdl1_busy", 64'(busy1), 64'(q1.size() != 0));
      check("mdl4_sout", 64'(sout4), 64'((q4.size() != 0) ? q4[0] : 1'b1));
      check("mdl4_busy", 64'(busy4), 64'(q4.size() != 0));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic send1(input logic [31:0] c, input logic [7:0] ctl);
    c1   = c;
    ctl1 = ctl;
    @(negedge clk);
    ctl1 = 8'hFF;
  endtask

  task automatic collect1(output int len, output logic [54:0] s);
    len = 0;
    s   = '0;
    while (busy1 === 1'b1 && len < 300) begin
      s = {s[53:0], sout1};
      len++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [31:0] c;
    logic [7:0]  ctl;
    int          len;
    logic [10:0] head;
    logic [10:0] tail;
  } vec_t;

  vec_t        tv[6];
  int          len;
  logic [54:0] s;
  logic [10:0] hd;
  logic [54:0] full1;
  bit          saw_act;

  initial begin
    tv[0] = '{32'h12345678, 8'h0A, 55, 11'b0_0_00010010_1, 11'b0_1_00001010_1};
    tv[1] = '{32'hDEADBEEF, 8'hC9, 11, 11'b0_1_11001001_1, 11'b0_1_11001001_1};
    tv[2] = '{32'h00000000, 8'h7F, 55, 11'b0_0_00000000_1, 11'b0_1_01111111_1};
    tv[3] = '{32'hFFFFFFFF, 8'h80, 11, 11'b0_1_10000000_1, 11'b0_1_10000000_1};
    tv[4] = '{32'h80000001, 8'h00, 55, 11'b0_0_10000000_1, 11'b0_1_00000000_1};
    tv[5] = '{32'hC3A50F00, 8'hFE, 11, 11'b0_1_11111110_1, 11'b0_1_11111110_1};
    full1 = {11'b0_0_00010010_1, 11'b0_0_00110100_1, 11'b0_0_01010110_1,
             11'b0_0_01111000_1, 11'b0_1_00001010_1};

    rst_n = 1'b0;
    c1 = '0; ctl1 = 8'hFF; c4 = '0; ctl4 = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mdl_on = 1'b1;
    check("rst_sout1", 64'(sout1), 64'd1);
    check("rst_busy1", 64'(busy1), 64'd0);
    check("rst_sout4", 64'(sout4), 64'd1);
    check("rst_busy4", 64'(busy4), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      send1(tv[i].c, tv[i].ctl);
      collect1(len, s);
      hd = (len >= 11 && len <= 55) ? s[len-1 -: 11] : 11'h0;
      check($sformatf("vec%0d_len", i), 64'(len), 64'(tv[i].len));
      check($sformatf("vec%0d_head", i), 64'(hd), 64'(tv[i].head));
      check($sformatf("vec%0d_tail", i), 64'(s[10:0]), 64'(tv[i].tail));
      check($sformatf("vec%0d_idle", i), 64'(sout1), 64'd1);
      if (i == 0) check("vec0_stream", 64'(s), 64'(full1));
    end

    saw_act = 1'b0;
    ctl1 = 8'hFF;
    repeat (100) begin
      @(negedge clk);
      if (sout1 !== 1'b1 || busy1 !== 1'b0) saw_act = 1'b1;
    end
    check("idle_100", 64'(saw_act), 64'd0);

    // Result offered while busy is dropped; the next one in the idle cycle starts at once.
    send1(32'h12345678, 8'h0A);
    repeat (4) @(negedge clk);
    ctl1 = 8'hA5;
    @(negedge clk);
    ctl1 = 8'hFF;
    collect1(len, s);
    check("ovl_len", 64'(len), 64'd50);
    check("ovl_tail", 64'(s[10:0]), 64'(11'b0_1_00001010_1));
    send1(32'h0, 8'hA5);
    check("ovl_a5_start_sout", 64'(sout1), 64'd0);
    check("ovl_a5_start_busy", 64'(busy1), 64'd1);
    collect1(len, s);
    check("ovl_a5_len", 64'(len), 64'd11);
    check("ovl_a5_tail", 64'(s[10:0]), 64'(11'b0_1_10100101_1));

    send1(32'h12345678, 8'h0A);
    repeat (26) @(negedge clk);
    check("pre_rst_busy", 64'(busy1), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_sout", 64'(sout1), 64'd1);
    check("mid_rst_busy", 64'(busy1), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_sout", 64'(sout1), 64'd1);
    send1(32'hFFFF0000, 8'h93);
    collect1(len, s);
    check("post_rst_len", 64'(len), 64'd11);
    check("post_rst_tail", 64'(s[10:0]), 64'(11'b0_1_10010011_1));

    c4 = 32'h12345678;
    ctl4 = 8'h0A;
    @(negedge clk);
    ctl4 = 8'hFF;
    len = 0;
    s   = '0;
    while (busy4 === 1'b1 && len < 1000) begin
      if (len % CPB4 == 0) s = {s[53:0], sout4};
      len++;
      @(negedge clk);
    end
    check("cpb4_busy_len", 64'(len), 64'd220);
    check("cpb4_stream", 64'(s), 64'(full1));
    check("cpb4_idle", 64'(sout4), 64'd1);

    for (int n = 0; n < 3000; n++) begin
      c1    = $urandom;
      ctl1  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      c4    = $urandom;
      ctl4  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      rst_n = ($urandom_range(0, 499) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    ctl1 = 8'hFF;
    ctl4 = 8'hFF;
    repeat (300) @(negedge clk);
    check("drain_busy1", 64'(busy1), 64'd0);
    check("drain_busy4", 64'(busy4), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
